// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit seven-segment scan controller.
// A shadow register holds the displayed value. A prescaler steps the digit
// select once per slot, and updates to the shadow are applied only at frame
// boundaries so that a frame never mixes two values.
// All outputs are registered. Each output is computed from the next-state
// values, so the anode and segment lines always match the dig_sel shown in
// the same cycle.
//
//   state | meaning
//   IDLE  | display blanked, prescaler/dig_sel held 0, loads go straight to shadow
//   SCAN  | digits multiplexed, loads deferred to the frame boundary
module seven_seg_scan_ctrl #(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] value_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [1:0]  dig_sel,
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        frame_done,
  output logic        load_pending
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dig_q, dig_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [15:0]      pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             fd_q, fd_d;
  logic             tick, wrap, lz, blank;
  logic [3:0]       nib;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Next-state for the sequencer, prescaler, shadow/pending regs and the outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dig_d      = dig_q;
    shadow_d   = shadow_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    fd_d       = 1'b0;
    tick       = 1'b0;
    wrap       = 1'b0;
    case (state_q)
      SCAN: begin
        if (!enable) begin
          // Leaving SCAN: flush any deferred value so it is not lost.
          state_d = IDLE;
          cnt_d   = '0;
          dig_d   = 2'd0;
          pend_d  = 1'b0;
          if (load)        shadow_d = value_in;
          else if (pend_q) shadow_d = pend_val_q;
        end else begin
          tick  = (cnt_q == CNT_LAST);
          cnt_d = tick ? '0 : cnt_q + 1'b1;
          dig_d = dig_q + {1'b0, tick};
          wrap  = tick && (dig_q == 2'd3);
          fd_d  = wrap;
          if (wrap) begin
            // A load on the boundary edge is newer than anything pending.
            pend_d = 1'b0;
            if (load)        shadow_d = value_in;
            else if (pend_q) shadow_d = pend_val_q;
          end else if (load) begin
            pend_d     = 1'b1;
            pend_val_d = value_in;
          end
        end
      end
      default: begin
        cnt_d  = '0;
        dig_d  = 2'd0;
        pend_d = 1'b0;
        if (load)   shadow_d = value_in;
        if (enable) state_d  = SCAN;
      end
    endcase

    case (dig_d)
      2'd1:    lz = (shadow_d[15:4] == 12'h000);
      2'd2:    lz = (shadow_d[15:8] == 8'h00);
      2'd3:    lz = (shadow_d[15:12] == 4'h0);
      default: lz = 1'b0;
    endcase
    blank = blank_lz && lz;
    nib   = shadow_d[{dig_d, 2'b00} +: 4];

    if (state_d == SCAN) begin
      an_d  = ~(4'b0001 << dig_d);
      seg_d = blank ? 7'h7F : hex_to_seg(nib);
    end else begin
      an_d  = 4'b1111;
      seg_d = 7'h7F;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dig_q      <= 2'd0;
      shadow_q   <= 16'h0000;
      pend_val_q <= 16'h0000;
      pend_q     <= 1'b0;
      an_q       <= 4'b1111;
      seg_q      <= 7'h7F;
      fd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dig_q      <= dig_d;
      shadow_q   <= shadow_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      fd_q       <= fd_d;
    end
  end

  assign dig_sel      = dig_q;
  assign an_n         = an_q;
  assign seg_n        = seg_q;
  assign frame_done   = fd_q;
  assign load_pending = pend_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl (CLK_DIV=4). The reference model tracks the
// elapsed SCAN time and derives the digit and frame position by division,
// then a per-cycle compare checks the DUT against it. Directed literal
// checks pin the expected display values.
module tb_seven_seg_scan_ctrl;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] value_in = 16'h0000;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [1:0]  dig_sel;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        frame_done;
  logic        load_pending;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit chk_en = 1'b0;

  seven_seg_scan_ctrl #(.CLK_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .value_in(value_in),
    .load(load), .blank_lz(blank_lz), .dig_sel(dig_sel), .an_n(an_n),
    .seg_n(seg_n), .frame_done(frame_done), .load_pending(load_pending)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16];
  initial seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // model state
  bit          m_scan = 1'b0;
  int          m_t = 0;
  logic [15:0] m_shadow = 16'h0000;
  bit          m_pend = 1'b0;
  logic [15:0] m_pv = 16'h0000;
  logic [1:0]  exp_dig = 2'd0;
  logic [3:0]  exp_an = 4'hF;
  logic [6:0]  exp_seg = 7'h7F;
  logic        exp_fd = 1'b0;
  logic        exp_lp = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // behavioural model: elapsed SCAN time decides digit and frame position
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_scan = 1'b0; m_t = 0; m_shadow = 16'h0000; m_pend = 1'b0; exp_fd = 1'b0;
      end else if (!m_scan) begin
        exp_fd = 1'b0;
        if (load) m_shadow = value_in;
        if (enable) begin m_scan = 1'b1; m_t = 0; end
      end else if (!enable) begin
        exp_fd = 1'b0;
        if (load) m_shadow = value_in;
        else if (m_pend) m_shadow = m_pv;
        m_pend = 1'b0;
        m_scan = 1'b0;
      end else begin
        m_t++;
        exp_fd = ((m_t % (4 * DIV)) == 0);
        if (exp_fd) begin
          if (load) m_shadow = value_in;
          else if (m_pend) m_shadow = m_pv;
          m_pend = 1'b0;
        end else if (load) begin
          m_pend = 1'b1;
          m_pv = value_in;
        end
      end
      exp_lp = m_pend;
      if (m_scan && rst_n) begin
        int d;
        int hi;
        d = (m_t / DIV) % 4;
        hi = int'(m_shadow) >> (4 * d);
        exp_dig = 2'(d);
        exp_an = ~(4'b0001 << d);
        exp_seg = (blank_lz && d > 0 && hi == 0) ? 7'h7F : seg_tab[hi % 16];
      end else begin
        exp_dig = 2'd0; exp_an = 4'hF; exp_seg = 7'h7F;
      end
    end
  end

  // per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && rst_n) begin
        check("m_dig_sel", 16'(dig_sel), 16'(exp_dig));
        check("m_an_n", 16'(an_n), 16'(exp_an));
        check("m_seg_n", 16'(seg_n), 16'(exp_seg));
        check("m_frame_done", 16'(frame_done), 16'(exp_fd));
        check("m_load_pending", 16'(load_pending), 16'(exp_lp));
      end
    end
  end

  task automatic adv(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  initial begin
    adv(3);
    rst_n = 1'b1;
    chk_en = 1'b1;
    adv(6);
    check("idle_an", 16'(an_n), 16'hF);
    check("idle_seg", 16'(seg_n), 16'h7F);
    check("idle_dig", 16'(dig_sel), 16'h0);

    load = 1'b1; value_in = 16'h12AF; adv(1);
    load = 1'b0; enable = 1'b1; adv(1);               // t=0
    check("d0_seg", 16'(seg_n), 16'h0E);
    check("d0_an", 16'(an_n), 16'hE);
    adv(4); check("d1_seg", 16'(seg_n), 16'h08); check("d1_an", 16'(an_n), 16'hD);
    adv(4); check("d2_seg", 16'(seg_n), 16'h24); check("d2_an", 16'(an_n), 16'hB);
    adv(4); check("d3_seg", 16'(seg_n), 16'h79); check("d3_an", 16'(an_n), 16'h7);
    adv(4); check("wrap_fd", 16'(frame_done), 16'h1); check("wrap_seg", 16'(seg_n), 16'h0E);
    adv(1); check("fd_clear", 16'(frame_done), 16'h0);   // t=17

    adv(3); load = 1'b1; value_in = 16'h0000;            // t=20
    adv(1); load = 1'b0; check("lp_set", 16'(load_pending), 16'h1);
    adv(3); load = 1'b1; value_in = 16'h8888;            // t=24
    adv(1); load = 1'b0;
    check("old_d2", 16'(seg_n), 16'h24); check("lp_hold", 16'(load_pending), 16'h1);
    adv(3); check("old_d3", 16'(seg_n), 16'h79);        // t=28
    adv(4); check("new_d0", 16'(seg_n), 16'h00);        // t=32
    check("lp_clr", 16'(load_pending), 16'h0);

    adv(15); load = 1'b1; value_in = 16'h3457;           // t=47, boundary edge
    adv(1); load = 1'b0;                                 // t=48
    check("coinc_seg", 16'(seg_n), 16'h78);
    check("coinc_lp", 16'(load_pending), 16'h0);
    check("coinc_fd", 16'(frame_done), 16'h1);

    adv(1); blank_lz = 1'b1; load = 1'b1; value_in = 16'h0050;   // t=49
    adv(1); load = 1'b0; check("lz_lp", 16'(load_pending), 16'h1);
    adv(14); check("lz_d0", 16'(seg_n), 16'h40);        // t=64
    adv(4); check("lz_d1", 16'(seg_n), 16'h12);
    adv(4); check("lz_d2", 16'(seg_n), 16'h7F); check("lz_d2_an", 16'(an_n), 16'hB);
    adv(4); check("lz_d3", 16'(seg_n), 16'h7F); check("lz_d3_an", 16'(an_n), 16'h7);
    load = 1'b1; value_in = 16'h0000;                    // t=76
    adv(1); load = 1'b0;
    adv(3); check("z_d0", 16'(seg_n), 16'h40);          // t=80
    adv(4); check("z_d1", 16'(seg_n), 16'h7F);          // t=84

    adv(5);                                              // t=89, mid digit2
    rst_n = 1'b0; enable = 1'b0;
    #1;
    check("rst_an", 16'(an_n), 16'hF);
    check("rst_seg", 16'(seg_n), 16'h7F);
    check("rst_dig", 16'(dig_sel), 16'h0);
    check("rst_fd", 16'(frame_done), 16'h0);
    #2 rst_n = 1'b1;
    adv(4); check("post_rst_an", 16'(an_n), 16'hF);
    enable = 1'b1;
    adv(1); check("post_rst_d0", 16'(seg_n), 16'h40);
    blank_lz = 1'b0; load = 1'b1; value_in = 16'hBEEF;
    adv(1); load = 1'b0; check("dis_lp", 16'(load_pending), 16'h1);
    enable = 1'b0;
    adv(1); check("dis_an", 16'(an_n), 16'hF); check("dis_lp_clr", 16'(load_pending), 16'h0);
    enable = 1'b1;
    adv(1); check("dis_commit", 16'(seg_n), 16'h0E);
    adv(20);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
